// File: rtl/hopfield_update_ctrl_if.sv
// Bus between the Hopfield recall controller and its environment: host control,
// weight-memory handshake and the prediction datapath hookup.
interface hopfield_update_ctrl_if #(
  parameter int N  = 20,
  parameter int WW = 10,
  parameter int SW = 8
);
  logic                 start;
  logic [2*N-1:0]       init_state;
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic [SW-1:0]        sweeps;
  logic [2*N-1:0]       state_out;
  logic                 w_req;
  logic [$clog2(N)-1:0] w_addr;
  logic                 w_valid;
  logic [WW*N-1:0]      w_row;
  logic [WW*N-1:0]      pred_weights;
  logic [2*N-1:0]       pred_x;
  logic signed [WW-1:0] pred_y;

  modport master (
    input  start, init_state, w_valid, w_row, pred_y,
    output busy, done, converged, sweeps, state_out, w_req, w_addr, pred_weights, pred_x
  );

  modport slave (
    output start, init_state, w_valid, w_row, pred_y,
    input  busy, done, converged, sweeps, state_out, w_req, w_addr, pred_weights, pred_x
  );
endinterface

// File: rtl/hopfield_update_ctrl.sv
// Hopfield recall sequencer: per-neuron fetch/eval/update sweeps until stable or limit.
// Define SYNC_UPDATE_EN for synchronous (snapshot/shadow) updates; default is in-place.
module hopfield_update_ctrl #(
  parameter int N          = 20,
  parameter int WW         = 10,
  parameter int SW         = 8,
  parameter int MAX_SWEEPS = 16
) (
  input logic                    clk,
  input logic                    rst,
  hopfield_update_ctrl_if.master bus
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [SW-1:0] SWEEP_LIMIT = SW'(MAX_SWEEPS);
  localparam logic signed [WW-1:0] Y_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EVAL   = 3'd2,
    S_UPDATE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } fsm_e;

  fsm_e                 fsm_q;
  logic [AW-1:0]        idx_q;
  logic [2*N-1:0]       state_q;
  logic [WW*N-1:0]      row_q;
  logic signed [WW-1:0] ysum_q;
  logic [SW-1:0]        sweeps_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 conv_q;
  logic                 w_req_q;
  logic                 changed_q;

  logic [SW-1:0]        sweeps_d;
  logic [1:0]           old_val_d;
  logic [1:0]           new_val_d;

  // A zero sum leaves the neuron as it was, including the 00/10 codes.
  function automatic logic [1:0] sign_update(input logic signed [WW-1:0] y, input logic [1:0] old);
    logic [1:0] r;
    if (y > Y_ZERO) r = 2'b01;
    else if (y < Y_ZERO) r = 2'b11;
    else r = old;
    return r;
  endfunction

`ifdef SYNC_UPDATE_EN
  logic [2*N-1:0] snap_q;
  logic [2*N-1:0] shadow_q;
  assign old_val_d  = snap_q[{idx_q, 1'b0} +: 2];
  assign bus.pred_x = snap_q;
`else
  assign old_val_d  = state_q[{idx_q, 1'b0} +: 2];
  assign bus.pred_x = state_q;
`endif

  assign new_val_d = sign_update(ysum_q, old_val_d);
  assign sweeps_d  = sweeps_q + SW'(1);

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.converged    = conv_q;
  assign bus.sweeps       = sweeps_q;
  assign bus.state_out    = state_q;
  assign bus.w_req        = w_req_q;
  assign bus.w_addr       = idx_q;
  assign bus.pred_weights = row_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      idx_q     <= '0;
      state_q   <= '0;
      row_q     <= '0;
      ysum_q    <= '0;
      sweeps_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
      w_req_q   <= 1'b0;
      changed_q <= 1'b0;
`ifdef SYNC_UPDATE_EN
      snap_q    <= '0;
      shadow_q  <= '0;
`endif
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= bus.init_state;
            idx_q     <= '0;
            sweeps_q  <= '0;
            conv_q    <= 1'b0;
            changed_q <= 1'b0;
            busy_q    <= 1'b1;
            w_req_q   <= 1'b1;
            fsm_q     <= S_FETCH;
`ifdef SYNC_UPDATE_EN
            snap_q    <= bus.init_state;
            shadow_q  <= bus.init_state;
`endif
          end else begin
            fsm_q <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (bus.w_valid) begin
            row_q   <= bus.w_row;
            w_req_q <= 1'b0;
            fsm_q   <= S_EVAL;
          end else begin
            fsm_q <= S_FETCH;
          end
        end
        S_EVAL: begin
          ysum_q <= bus.pred_y;
          fsm_q  <= S_UPDATE;
        end
        S_UPDATE: begin
`ifdef SYNC_UPDATE_EN
          shadow_q[{idx_q, 1'b0} +: 2] <= new_val_d;
`else
          state_q[{idx_q, 1'b0} +: 2] <= new_val_d;
`endif
          if (new_val_d != old_val_d) changed_q <= 1'b1;
          if (idx_q == LAST_IDX) begin
            fsm_q <= S_CHECK;
          end else begin
            idx_q   <= idx_q + AW'(1);
            w_req_q <= 1'b1;
            fsm_q   <= S_FETCH;
          end
        end
        S_CHECK: begin
          sweeps_q <= sweeps_d;
`ifdef SYNC_UPDATE_EN
          state_q  <= shadow_q;
`endif
          if (!changed_q || (sweeps_d == SWEEP_LIMIT)) begin
            conv_q <= !changed_q;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            fsm_q  <= S_DONE;
          end else begin
            idx_q     <= '0;
            changed_q <= 1'b0;
            w_req_q   <= 1'b1;
            fsm_q     <= S_FETCH;
`ifdef SYNC_UPDATE_EN
            snap_q    <= shadow_q;
`endif
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          fsm_q  <= S_IDLE;
        end
        default: begin
          fsm_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hopfield_update_ctrl.sv
// Self-checking bench: algorithmic recall model, behavioural weight memory and dot-product datapath.
module tb_hopfield_update_ctrl;
  localparam int N    = 20;
  localparam int WW   = 10;
  localparam int SW   = 8;
  localparam int MAXS = 3;
`ifdef SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int             W [N][N];
  logic [2*N-1:0] init_g;
  int             wait_mode = 0;
  bit             noise_en = 1'b0;
  int             total_waits = 0;
  int             fetch_cnt = 0;
  bit             armed = 1'b0;
  int             wcnt = 0;

  logic [2*N-1:0] m_state;
  int             m_sweeps;
  bit             m_conv;
  int             last_len;

  hopfield_update_ctrl_if #(.N(N), .WW(WW), .SW(SW)) bus ();

  hopfield_update_ctrl #(.N(N), .WW(WW), .SW(SW), .MAX_SWEEPS(MAXS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in for the prediction datapath: signed dot product wrapped to WW bits.
  function automatic logic signed [WW-1:0] dot(input logic [WW*N-1:0] wp, input logic [2*N-1:0] xp);
    int acc;
    logic signed [WW-1:0] wk;
    logic signed [1:0] xk;
    acc = 0;
    for (int k = 0; k < N; k++) begin
      wk = wp[WW*k +: WW];
      xk = xp[2*k +: 2];
      acc += int'(wk) * int'(xk);
    end
    return WW'(acc);
  endfunction

  always_comb bus.pred_y = dot(bus.pred_weights, bus.pred_x);

  function automatic logic [WW*N-1:0] pack_row(input int r);
    logic [WW*N-1:0] row;
    for (int k = 0; k < N; k++) row[WW*k +: WW] = WW'(W[r][k]);
    return row;
  endfunction

  function automatic int code_val(input logic [1:0] c);
    return int'($signed(c));
  endfunction

  // Reference recall: whole sweeps over integer neuron values.
  task automatic model_run(input logic [2*N-1:0] init);
    logic [1:0] cur [N];
    logic [1:0] nxt [N];
    logic [1:0] ref_v [N];
    logic [1:0] nv;
    logic signed [WW-1:0] y;
    int acc;
    bit ch;
    for (int j = 0; j < N; j++) cur[j] = init[2*j +: 2];
    m_sweeps = 0;
    m_conv = 1'b0;
    for (int s = 0; s < MAXS; s++) begin
      ch = 1'b0;
      ref_v = cur;
      nxt = cur;
      for (int i = 0; i < N; i++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc += W[i][k] * code_val(SYNC ? ref_v[k] : nxt[k]);
        y = WW'(acc);
        if (y > 0) nv = 2'b01;
        else if (y < 0) nv = 2'b11;
        else nv = nxt[i];
        if (nv != (SYNC ? ref_v[i] : nxt[i])) ch = 1'b1;
        nxt[i] = nv;
      end
      cur = nxt;
      m_sweeps++;
      if (!ch) begin
        m_conv = 1'b1;
        break;
      end
    end
    for (int j = 0; j < N; j++) m_state[2*j +: 2] = cur[j];
  endtask

  // Weight memory: wait states per request, noise on w_valid while no request is open.
  always @(negedge clk) begin
    if (rst || !bus.w_req) begin
      if (armed) fetch_cnt++;
      armed = 1'b0;
      bus.w_valid = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int k = 0; k < N; k++) bus.w_row[WW*k +: WW] = WW'($urandom);
    end else begin
      chk("w_addr", 64'(bus.w_addr), 64'(fetch_cnt % N));
      if (!armed) begin
        armed = 1'b1;
        case (wait_mode)
          1: wcnt = $urandom_range(0, 2);
          2: wcnt = ((fetch_cnt % N) == 7) ? 3 : 0;
          default: wcnt = 0;
        endcase
        total_waits += wcnt;
      end
      if (wcnt == 0) begin
        bus.w_valid = 1'b1;
        bus.w_row = pack_row(fetch_cnt % N);
      end else begin
        bus.w_valid = 1'b0;
        wcnt--;
      end
    end
  end

  task automatic clear_w();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) W[i][k] = 0;
  endtask

  task automatic run_recall(input string name, input int wmode, input bit mstart);
    int st;
    bit seen;
    model_run(init_g);
    wait_mode = wmode;
    @(negedge clk);
    total_waits = 0;
    fetch_cnt = 0;
    bus.start = 1'b1;
    bus.init_state = init_g;
    @(negedge clk);
    bus.start = 1'b0;
    st = cyc;
    seen = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      chk({name, "_busy"}, 64'(bus.busy), 64'd1);
      if (mstart && t == 20) begin
        bus.start = 1'b1;
        bus.init_state = ~init_g;
      end else begin
        bus.start = 1'b0;
        bus.init_state = init_g;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    last_len = cyc - st;
    chk({name, "_len"}, 64'(last_len), 64'(m_sweeps * (3 * N + 1) + total_waits));
    chk({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({name, "_state"}, 64'(bus.state_out), 64'(m_state));
    chk({name, "_sweeps"}, 64'(bus.sweeps), 64'(m_sweeps));
    chk({name, "_conv"}, 64'(bus.converged), 64'(m_conv));
    chk({name, "_fetches"}, 64'(fetch_cnt), 64'(m_sweeps * N));
    @(negedge clk);
    chk({name, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({name, "_state_hold"}, 64'(bus.state_out), 64'(m_state));
    chk({name, "_sweeps_hold"}, 64'(bus.sweeps), 64'(m_sweeps));
    chk({name, "_conv_hold"}, 64'(bus.converged), 64'(m_conv));
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_busy"}, 64'(bus.busy), 64'd0);
    chk({name, "_done"}, 64'(bus.done), 64'd0);
    chk({name, "_conv"}, 64'(bus.converged), 64'd0);
    chk({name, "_sweeps"}, 64'(bus.sweeps), 64'd0);
    chk({name, "_state"}, 64'(bus.state_out), 64'd0);
    chk({name, "_w_req"}, 64'(bus.w_req), 64'd0);
    chk({name, "_w_addr"}, 64'(bus.w_addr), 64'd0);
    chk({name, "_pred_w"}, 64'(bus.pred_weights == '0), 64'd1);
  endtask

  initial begin
    int st;
    bus.start = 1'b0;
    bus.init_state = '0;
    clear_w();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // All-zero weights, all +1: one sweep, converged.
    init_g = 40'h55555_55555;
    run_recall("t1", 0, 1'b0);
    chk("t1_len_lit", 64'(last_len), 64'd61);
    chk("t1_model_sweeps", 64'(m_sweeps), 64'd1);
    chk("t1_model_state", 64'(m_state), 64'h55555_55555);

    // One coupling flips neuron 0 in sweep 1.
    W[0][1] = 5;
    init_g = 40'h7;
    run_recall("t2", 0, 1'b0);
    chk("t2_model_state", 64'(m_state), 64'h5);
    chk("t2_model_sweeps", 64'(m_sweeps), 64'd2);
    chk("t2_model_conv", 64'(m_conv), 64'd1);

    // Self-inhibit oscillation runs into the sweep limit.
    clear_w();
    W[0][0] = -1;
    init_g = 40'h1;
    run_recall("t3", 1, 1'b0);
    chk("t3_model_state", 64'(m_state), 64'h3);
    chk("t3_model_sweeps", 64'(m_sweeps), 64'd3);
    chk("t3_model_conv", 64'(m_conv), 64'd0);

    // Row 7 delayed by three cycles.
    clear_w();
    init_g = 40'h55555_55555;
    run_recall("t4", 2, 1'b0);
    chk("t4_len_lit", 64'(last_len), 64'd64);

    // Reset in the EVAL of neuron 5 aborts to idle.
    wait_mode = 0;
    @(negedge clk);
    fetch_cnt = 0;
    bus.start = 1'b1;
    bus.init_state = init_g;
    @(negedge clk);
    bus.start = 1'b0;
    st = cyc;
    while (cyc < st + 16) @(negedge clk);
    chk("t5_eval_addr", 64'(bus.w_addr), 64'd5);
    chk("t5_eval_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check_reset_state("t5_abort");
    rst = 1'b0;
    bus.start = 1'b0;
    run_recall("t5_fresh", 0, 1'b0);
    chk("t5_len_lit", 64'(last_len), 64'd61);

    // Start pulses while busy are ignored.
    run_recall("t6_zero", 0, 1'b1);
    chk("t6_len_lit", 64'(last_len), 64'd61);
    W[0][1] = -1;
    W[1][0] = -1;
    init_g = 40'h5;
    run_recall("t6_pair", 0, 1'b1);
    if (SYNC) begin
      chk("t6_model_state", 64'(m_state), 64'hF);
      chk("t6_model_conv", 64'(m_conv), 64'd0);
      chk("t6_model_sweeps", 64'(m_sweeps), 64'd3);
    end else begin
      chk("t6_model_state", 64'(m_state), 64'h7);
      chk("t6_model_conv", 64'(m_conv), 64'd1);
      chk("t6_model_sweeps", 64'(m_sweeps), 64'd2);
    end

    // Randomized weights, states, memory latency and bus noise.
    noise_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++)
          W[i][k] = (r == 7) ? int'($urandom_range(0, 1023)) - 512 : int'($urandom_range(0, 8)) - 4;
      for (int j = 0; j < N; j++) init_g[2*j +: 2] = 2'($urandom_range(0, 3));
      run_recall("rand", 1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
